// File: rtl/braille_dwell_timer.sv
// Millisecond dwell timer: counts 1 ms ticks from the LFSR tick generator,
// with pause, abort, a completion pulse and a watchdog on a silent generator.
module braille_dwell_timer #(
  parameter int DUR_W       = 12,
  parameter int WDOG_W      = 16,
  parameter int WDOG_CYCLES = 65535
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DUR_W-1:0] duration_ms,
  input  logic             pause,
  input  logic             abort,
  input  logic             timeout1ms,
  output logic             tick_enable,
  output logic             busy,
  output logic             done,
  output logic [DUR_W-1:0] remaining,
  output logic             tick_err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RUN   = 3'd1;
  localparam logic [2:0] S_PAUSE = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_ERR   = 3'd4;

  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);

  logic [2:0]        state;
  logic [WDOG_W-1:0] wdog;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      tick_enable <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      remaining   <= '0;
      tick_err    <= 1'b0;
      wdog        <= '0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state       <= S_IDLE;
        tick_enable <= 1'b0;
        busy        <= 1'b0;
        remaining   <= '0;
        tick_err    <= 1'b0;
        wdog        <= '0;
      end else begin
        case (state)
          S_IDLE, S_ERR: begin
            if (start) begin
              tick_err <= 1'b0;
              wdog     <= '0;
              if (duration_ms != '0) begin
                state       <= S_RUN;
                remaining   <= duration_ms;
                busy        <= 1'b1;
                tick_enable <= 1'b1;
              end else begin
                // zero-length dwell completes without waking the generator
                state     <= S_DONE;
                done      <= 1'b1;
                remaining <= '0;
              end
            end
          end
          S_RUN: begin
            if (timeout1ms) begin
              wdog <= '0;
              if (remaining != '0) remaining <= remaining - 1'b1;
              // completion beats a same-cycle pause
              if (remaining <= DUR_W'(1)) begin
                state       <= S_DONE;
                done        <= 1'b1;
                busy        <= 1'b0;
                tick_enable <= 1'b0;
              end else if (pause) begin
                state       <= S_PAUSE;
                tick_enable <= 1'b0;
              end
            end else if (wdog == WDOG_LAST) begin
              state       <= S_ERR;
              tick_err    <= 1'b1;
              tick_enable <= 1'b0;
              busy        <= 1'b0;
              wdog        <= '0;
            end else if (pause) begin
              state       <= S_PAUSE;
              tick_enable <= 1'b0;
              wdog        <= '0;
            end else begin
              wdog <= wdog + 1'b1;
            end
          end
          S_PAUSE: begin
            // generator held off here, so resuming starts a fresh 1 ms interval
            wdog <= '0;
            if (!pause) begin
              state       <= S_RUN;
              tick_enable <= 1'b1;
            end
          end
          S_DONE:  state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
